glyph_scroller: RTL and testbench

// Per-pixel address generator feeding the glyph ROM (sym/xaddr/yaddr) of the text-scroller layer.

---
 rtl/glyph_scroller_pkg.sv | 22 ++
 rtl/glyph_scroller_if.sv | 30 +++
 rtl/glyph_scroller_scroll_ctrl.sv | 73 +++++++
 rtl/glyph_scroller.sv | 95 +++++++++
 tb/tb_glyph_scroller.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/glyph_scroller_pkg.sv
// Shared constants and types for the text-scroller glyph address path.
// Imported by the interface, the scroll controller and the pixel pipeline.
package glyph_scroller_pkg;

  localparam int GLYPH_W     = 32;
  localparam int GLYPH_SHIFT = 5;
  localparam int SYM_W       = 2;
  localparam int DY_W        = 11;
  localparam int H_VISIBLE   = 640;
  localparam int V_VISIBLE   = 480;

  typedef enum logic {
    ST_SCROLL = 1'b0,
    ST_HOLD   = 1'b1
  } scroll_state_e;

  // Hold counter must reach HOLD_FRAMES-1; keep at least one bit
  function automatic int holdWidth(input int frames);
    return (frames > 2) ? $clog2(frames) : 1;
  endfunction

endpackage

// File: rtl/glyph_scroller_if.sv
// Beam-side inputs and ROM-side outputs of the glyph scroller, bundled.
// The master drives beam/timing, the slave (glyph_scroller) returns addresses.
interface glyph_scroller_if;
  import glyph_scroller_pkg::*;

  logic [9:0]       i_hpos;
  logic [9:0]       i_vpos;
  logic             i_hsync_in;
  logic             i_vsync_in;
  logic             i_de_in;
  logic             i_pause_en;
  logic [SYM_W-1:0] o_sym;
  logic [4:0]       o_xaddr;
  logic [4:0]       o_yaddr;
  logic             o_in_band;
  logic             o_hsync_out;
  logic             o_vsync_out;
  logic             o_de_out;

  modport master (
    output i_hpos, i_vpos, i_hsync_in, i_vsync_in, i_de_in, i_pause_en,
    input  o_sym, o_xaddr, o_yaddr, o_in_band, o_hsync_out, o_vsync_out, o_de_out
  );

  modport slave (
    input  i_hpos, i_vpos, i_hsync_in, i_vsync_in, i_de_in, i_pause_en,
    output o_sym, o_xaddr, o_yaddr, o_in_band, o_hsync_out, o_vsync_out, o_de_out
  );

endinterface

// File: rtl/glyph_scroller_scroll_ctrl.sv
// Per-frame scroll offset: frame tick detection plus the SCROLL/HOLD pause FSM.
// The offset only moves on the tick, which lies in vblank.
module scroll_ctrl #(
  parameter int W           = 9,
  parameter int SPEED       = 2,
  parameter int HOLD_FRAMES = 30,
  parameter int V_VISIBLE   = 480
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [9:0]   i_hpos,
  input  logic [9:0]   i_vpos,
  input  logic         i_pause_en,
  output logic [W-1:0] o_scroll_x
);
  import glyph_scroller_pkg::*;

  localparam int HW = holdWidth(HOLD_FRAMES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);

  scroll_state_e r_state;
  scroll_state_e w_state_nx;
  logic          r_tick;
  logic [W-1:0]  r_scroll_x;
  logic [W-1:0]  w_scroll_nx;
  logic [W-1:0]  w_step;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_nx;

  assign w_step     = r_scroll_x + W'(SPEED);
  assign o_scroll_x = r_scroll_x;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick     <= 1'b0;
      r_state    <= ST_SCROLL;
      r_scroll_x <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_tick     <= (i_vpos == 10'(V_VISIBLE)) && (i_hpos == 10'd0);
      r_state    <= w_state_nx;
      r_scroll_x <= w_scroll_nx;
      r_hold_cnt <= w_hold_nx;
    end
  end

  // The glyph-aligned frame itself is the first held frame, hence the -1 load
  always_comb begin
    w_state_nx  = r_state;
    w_scroll_nx = r_scroll_x;
    w_hold_nx   = r_hold_cnt;
    if (r_tick) begin
      case (r_state)
        ST_SCROLL: begin
          w_scroll_nx = w_step;
          if ((w_step[4:0] == 5'd0) && i_pause_en && (HOLD_FRAMES != 0)) begin
            w_hold_nx  = HOLD_LOAD;
            w_state_nx = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!i_pause_en || (r_hold_cnt == '0)) begin
            w_state_nx = ST_SCROLL;
          end else begin
            w_hold_nx = r_hold_cnt - 1'b1;
          end
        end
        default: w_state_nx = ST_SCROLL;
      endcase
    end
  end

endmodule

// File: rtl/glyph_scroller.sv
// Two-stage pixel pipeline mapping beam position + scroll offset onto a looping
// glyph message; sync/de are delayed by the same two stages.
module glyph_scroller #(
  parameter int                   MSG_LEN     = 16,
  parameter logic [2*MSG_LEN-1:0] MSG         = 32'h1B1B_E4E4,
  parameter int                   SPEED       = 2,
  parameter int                   BAND_Y      = 200,
  parameter int                   YSHIFT      = 1,
  parameter int                   HOLD_FRAMES = 30,
  parameter int                   V_VISIBLE   = 480
) (
  input logic               clk,
  input logic               rst_n,
  glyph_scroller_if.slave   bus
);
  import glyph_scroller_pkg::*;

  localparam int MSG_W  = $clog2(MSG_LEN);
  localparam int W      = MSG_W + GLYPH_SHIFT;
  localparam int BAND_H = GLYPH_W << YSHIFT;

  logic [W-1:0]     w_scroll_x;
  logic [W-1:0]     w_xw;
  logic [DY_W-1:0]  w_dy;
  logic             w_band;
  logic [MSG_W-1:0] w_glyph;
  logic [SYM_W-1:0] w_sym;

  logic [W-1:0]     r_xw;
  logic [4:0]       r_yrow;
  logic             r_band;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;

  scroll_ctrl #(
    .W           (W),
    .SPEED       (SPEED),
    .HOLD_FRAMES (HOLD_FRAMES),
    .V_VISIBLE   (V_VISIBLE)
  ) u_scroll_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hpos     (bus.i_hpos),
    .i_vpos     (bus.i_vpos),
    .i_pause_en (bus.i_pause_en),
    .o_scroll_x (w_scroll_x)
  );

  // dy is treated as signed: lines above the band come out with the top bit set
  assign w_xw    = W'(bus.i_hpos) + w_scroll_x;
  assign w_dy    = {1'b0, bus.i_vpos} - DY_W'(BAND_Y);
  assign w_band  = bus.i_de_in & ~w_dy[DY_W-1] & (w_dy < DY_W'(BAND_H));
  assign w_glyph = r_xw[W-1:GLYPH_SHIFT];
  assign w_sym   = SYM_W'(MSG >> {w_glyph, 1'b0});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xw    <= '0;
      r_yrow  <= '0;
      r_band  <= 1'b0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
      r_de    <= 1'b0;
    end else begin
      r_xw    <= w_xw;
      r_yrow  <= w_dy[4+YSHIFT:YSHIFT];
      r_band  <= w_band;
      r_hsync <= bus.i_hsync_in;
      r_vsync <= bus.i_vsync_in;
      r_de    <= bus.i_de_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.o_sym       <= '0;
      bus.o_xaddr     <= '0;
      bus.o_yaddr     <= '0;
      bus.o_in_band   <= 1'b0;
      bus.o_hsync_out <= 1'b0;
      bus.o_vsync_out <= 1'b0;
      bus.o_de_out    <= 1'b0;
    end else begin
      bus.o_sym       <= r_band ? w_sym : '0;
      bus.o_xaddr     <= r_band ? r_xw[4:0] : 5'd0;
      bus.o_yaddr     <= r_band ? r_yrow : 5'd0;
      bus.o_in_band   <= r_band;
      bus.o_hsync_out <= r_hsync;
      bus.o_vsync_out <= r_vsync;
      bus.o_de_out    <= r_de;
    end
  end

endmodule

// File: tb/tb_glyph_scroller.sv
// Randomised scoreboard bench for glyph_scroller against a frame-level model
// of the scrolling message, band geometry and pause hold.
module tb_glyph_scroller;
  import glyph_scroller_pkg::*;

  localparam int               MSG_LEN     = 16;
  localparam logic [31:0]      MSG         = 32'h1B1B_E4E4;
  localparam int               SPEED       = 2;
  localparam int               BAND_Y      = 200;
  localparam int               YSHIFT      = 1;
  localparam int               HOLD_FRAMES = 30;
  localparam int               LOOP_PIX    = MSG_LEN * 32;
  localparam int               BAND_LINES  = 32 << YSHIFT;

  typedef struct {
    int         due;
    logic [1:0] sym;
    logic [4:0] xaddr;
    logic [4:0] yaddr;
    logic       inBand;
    logic       hs;
    logic       vs;
    logic       de;
  } expect_t;

  logic    clk;
  logic    rstN;
  int      cycleCnt = 0;
  int      compared = 0;
  int      mismatched = 0;
  int      modelScroll = 0;
  int      modelHoldLeft = 0;
  expect_t sbQueue[$];

  glyph_scroller_if bus ();

  glyph_scroller #(
    .MSG_LEN     (MSG_LEN),
    .MSG         (MSG),
    .SPEED       (SPEED),
    .BAND_Y      (BAND_Y),
    .YSHIFT      (YSHIFT),
    .HOLD_FRAMES (HOLD_FRAMES),
    .V_VISIBLE   (V_VISIBLE)
  ) dut (
    .clk   (clk),
    .rst_n (rstN),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Message-loop view: the visible window starts modelScroll pixels into the loop
  function automatic expect_t modelPixel(input int hpos, input int vpos,
                                         input logic hs, input logic vs, input logic de);
    expect_t    e;
    logic [31:0] msgBits;
    int         line;
    int         pos;
    msgBits  = MSG;
    line     = vpos - BAND_Y;
    pos      = (hpos + modelScroll) % LOOP_PIX;
    e.due    = 0;
    e.hs     = hs;
    e.vs     = vs;
    e.de     = de;
    e.inBand = de && (line >= 0) && (line < BAND_LINES);
    e.sym    = 2'd0;
    e.xaddr  = 5'd0;
    e.yaddr  = 5'd0;
    if (e.inBand) begin
      e.sym   = msgBits[2*(pos/32) +: 2];
      e.xaddr = 5'(pos % 32);
      e.yaddr = 5'((line >> YSHIFT) % 32);
    end
    return e;
  endfunction

  function automatic expect_t zeroExpect();
    expect_t e;
    e.due = 0; e.sym = 2'd0; e.xaddr = 5'd0; e.yaddr = 5'd0;
    e.inBand = 1'b0; e.hs = 1'b0; e.vs = 1'b0; e.de = 1'b0;
    return e;
  endfunction

  // Holding means the next modelHoldLeft ticks leave the offset where it is
  function automatic void modelTick(input logic pause);
    if (modelHoldLeft > 0) begin
      if (!pause) modelHoldLeft = 0;
      else        modelHoldLeft = modelHoldLeft - 1;
    end else begin
      modelScroll = (modelScroll + SPEED) % LOOP_PIX;
      if ((modelScroll % 32 == 0) && pause && (HOLD_FRAMES > 0))
        modelHoldLeft = HOLD_FRAMES;
    end
  endfunction

  task automatic applyStimulus(input logic rstVal, input int hpos, input int vpos,
                               input logic hs, input logic vs, input logic de,
                               input logic pause);
    expect_t e;
    @(posedge clk);
    #1;
    rstN           = rstVal;
    bus.i_hpos     = 10'(hpos);
    bus.i_vpos     = 10'(vpos);
    bus.i_hsync_in = hs;
    bus.i_vsync_in = vs;
    bus.i_de_in    = de;
    bus.i_pause_en = pause;
    if (!rstVal) begin
      foreach (sbQueue[i])
        if (sbQueue[i].due > cycleCnt) sbQueue[i] = '{sbQueue[i].due, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      modelScroll   = 0;
      modelHoldLeft = 0;
      e = zeroExpect();
    end else begin
      e = modelPixel(hpos, vpos, hs, vs, de);
      if ((vpos == V_VISIBLE) && (hpos == 0)) modelTick(pause);
    end
    e.due = cycleCnt + 2;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    compared++;
    if (bus.o_sym !== e.sym || bus.o_xaddr !== e.xaddr || bus.o_yaddr !== e.yaddr ||
        bus.o_in_band !== e.inBand || bus.o_hsync_out !== e.hs ||
        bus.o_vsync_out !== e.vs || bus.o_de_out !== e.de) begin
      mismatched++;
      $display("[TB] FAIL pixel@cyc%0d: got sym=%0d x=%0d y=%0d band=%b hs=%b vs=%b de=%b, want sym=%0d x=%0d y=%0d band=%b hs=%b vs=%b de=%b",
               e.due, bus.o_sym, bus.o_xaddr, bus.o_yaddr, bus.o_in_band, bus.o_hsync_out,
               bus.o_vsync_out, bus.o_de_out, e.sym, e.xaddr, e.yaddr, e.inBand, e.hs, e.vs, e.de);
    end
  endtask

  always @(negedge clk) begin
    while (sbQueue.size() > 0 && sbQueue[0].due <= cycleCnt) begin
      expect_t e;
      e = sbQueue.pop_front();
      if (e.due == cycleCnt) begin
        checkOutput(e);
      end else begin
        compared++;
        mismatched++;
        $display("[TB] FAIL stale: entry due %0d still queued at %0d", e.due, cycleCnt);
      end
    end
  end

  task automatic randPixel(input logic pause, input logic inBand);
    int vpos;
    vpos = inBand ? $urandom_range(BAND_Y + BAND_LINES - 1, BAND_Y) : $urandom_range(V_VISIBLE - 1, 0);
    applyStimulus(1'b1, $urandom_range(639, 0), vpos, 1'($urandom), 1'($urandom),
                  inBand ? 1'b1 : 1'($urandom), pause);
  endtask

  task automatic doFrame(input logic pause);
    applyStimulus(1'b1, 0, V_VISIBLE, 1'($urandom), 1'($urandom), 1'b0, pause);
    applyStimulus(1'b1, 5, V_VISIBLE + 1, 1'($urandom), 1'($urandom), 1'b0, pause);
    applyStimulus(1'b1, 6, V_VISIBLE + 1, 1'($urandom), 1'($urandom), 1'b0, pause);
    applyStimulus(1'b1, 10, BAND_Y + 10, 1'($urandom), 1'($urandom), 1'b1, pause);
    randPixel(pause, 1'b1);
    randPixel(pause, 1'b0);
  endtask

  task automatic doReset(input int cycles, input logic pause);
    for (int i = 0; i < cycles; i++)
      applyStimulus(1'b0, $urandom_range(639, 0), BAND_Y + 5, 1'($urandom), 1'($urandom), 1'b1, pause);
  endtask

  initial begin
    rstN = 1'b0;
    bus.i_hpos = '0; bus.i_vpos = '0; bus.i_hsync_in = 1'b0;
    bus.i_vsync_in = 1'b0; bus.i_de_in = 1'b0; bus.i_pause_en = 1'b0;

    doReset(3, 1'b0);
    applyStimulus(1'b1, 37, BAND_Y + 9, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 100, 199, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 101, 200, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 102, 263, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 103, 264, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 104, 230, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 150; i++) randPixel(1'b0, 1'($urandom));

    $display("[TB] scrolling 256 frames without pause");
    for (int f = 0; f < 256; f++) doFrame(1'b0);

    $display("[TB] mid-frame reset");
    for (int f = 0; f < 5; f++) doFrame(1'b0);
    randPixel(1'b0, 1'b1);
    doReset(2, 1'b0);
    for (int i = 0; i < 6; i++) randPixel(1'b0, 1'b1);

    $display("[TB] glyph-aligned hold");
    for (int f = 0; f < 52; f++) doFrame(1'b1);

    $display("[TB] pause released during hold");
    doReset(2, 1'b1);
    for (int f = 0; f < 20; f++) doFrame(1'b1);
    for (int f = 0; f < 6; f++) doFrame(1'b0);
    for (int i = 0; i < 40; i++) randPixel(1'b0, 1'($urandom));

    repeat (4) @(posedge clk);
    @(negedge clk);
    if (sbQueue.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d entries left, want 0", sbQueue.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
